// File: rtl/iopad_hdx_pkg.sv
// iopad_hdx_pkg: shared types and helpers for the half-duplex pad link.
//   hdx_state_e : link controller states (the parity states are only entered
//                 when IOPAD_HDX_PARITY_EN is defined)
//   DATA_W      : payload width of one UART frame
//   cnt_w()     : width needed for a counter that holds 0..max_val
package iopad_hdx_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      TX_START  = 4'd1,
      TX_DATA   = 4'd2,
      TX_PARITY = 4'd3,
      TX_STOP   = 4'd4,
      TURN      = 4'd5,
      RX_WAIT   = 4'd6,
      RX_START  = 4'd7,
      RX_DATA   = 4'd8,
      RX_PARITY = 4'd9,
      RX_STOP   = 4'd10
   } hdx_state_e;

   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/iopad_hdx_link_sync.sv
// iopad_sync2: two-flop synchroniser for the asynchronous pad input.
//   clk, rst_n : clock, asynchronous active-low reset (flops reset to 1 = idle line)
//   d          : raw pad value; anything other than a clean 0 reads as 1,
//                matching the external pull-up on the line
//   q          : synchronised value
module iopad_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;
   logic       d_clean;

   always_comb begin
      d_clean = (d === 1'b0) ? 1'b0 : 1'b1;
      sync_d  = {sync_q[0], d_clean};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/iopad_hdx_link.sv
// iopad_hdx_link: core-side controller for one bidirectional pad running a
// half-duplex UART-framed link (send one command byte, turn the pad around,
// optionally receive one response byte).
// Optional feature: define IOPAD_HDX_PARITY_EN for 8E1 framing (even parity
// bit after bit 7 in both directions); default build is 8N1.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   tx_valid/tx_ready    : command handshake; tx_data sent LSB first,
//                          expect_rsp selects whether a response is received
//   rx_valid             : one-cycle pulse, rx_data/rx_err valid (held after)
//   timeout              : one-cycle pulse, no start bit in TIMEOUT_BITS periods
//   busy                 : transaction in progress
//   pad_inp/pad_oen      : pad cell I and OEN (1 = drive)
//   pad_outp             : pad cell C, only looked at while the pad is released
module iopad_hdx_link
   import iopad_hdx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,   // must be >= 4
   parameter int TURN_BITS    = 2,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              expect_rsp,
   output logic              tx_ready,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_err,
   output logic              timeout,
   output logic              busy,
   output logic              pad_inp,
   output logic              pad_oen,
   input  logic              pad_outp
);

   localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int BW     = cnt_w(CLKS_PER_BIT - 1);
   localparam int PW     = cnt_w((TURN_BITS > DATA_W) ? TURN_BITS : DATA_W);
   localparam int TW     = cnt_w(TO_CYC + CLKS_PER_BIT);
   localparam int IW     = $clog2(DATA_W);

   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_MID   = BW'(CLKS_PER_BIT / 2);
   localparam logic [PW-1:0] DATA_LAST = PW'(DATA_W - 1);
   localparam logic [PW-1:0] TURN_LAST = PW'(TURN_BITS - 1);
   localparam logic [TW-1:0] TO_LIMIT  = TW'(TO_CYC);

   hdx_state_e        state_q, state_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]     per_q, per_d;        // bit periods elapsed within a state
   logic [TW-1:0]     to_cnt_q, to_cnt_d;  // cycles since RX_WAIT entry
   logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
   logic              exp_rsp_q, exp_rsp_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_err_q, rx_err_d;
   logic              rx_valid_q, rx_valid_d;
   logic              pad_oen_q, pad_oen_d;
   logic              pad_inp_q, pad_inp_d;
   logic              line_prev_q;
   logic              line_s;
   logic              bit_end;
   logic              start_edge;
`ifdef IOPAD_HDX_PARITY_EN
   logic              par_err_q, par_err_d;
`endif

   iopad_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_outp),
      .q     (line_s)
   );

   assign bit_end    = (bit_cnt_q == BIT_LAST);
   assign start_edge = line_prev_q & ~line_s;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_end ? '0 : bit_cnt_q + BW'(1);
      per_d      = per_q;
      to_cnt_d   = to_cnt_q;
      tx_byte_d  = tx_byte_q;
      exp_rsp_d  = exp_rsp_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_err_d   = rx_err_q;
      rx_valid_d = 1'b0;
      timeout    = 1'b0;
`ifdef IOPAD_HDX_PARITY_EN
      par_err_d  = par_err_q;
`endif

      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               tx_byte_d = tx_data;
               exp_rsp_d = expect_rsp;
               state_d   = TX_START;
            end
         end
         TX_START: if (bit_end) state_d = TX_DATA;
         TX_DATA: begin
            if (bit_end) begin
               if (per_q == DATA_LAST) begin
`ifdef IOPAD_HDX_PARITY_EN
                  state_d = TX_PARITY;
`else
                  state_d = TX_STOP;
`endif
               end else begin
                  per_d = per_q + PW'(1);
               end
            end
         end
`ifdef IOPAD_HDX_PARITY_EN
         TX_PARITY: if (bit_end) state_d = TX_STOP;
`endif
         TX_STOP: if (bit_end) state_d = TURN;
         TURN: begin
            if (bit_end) begin
               if (per_q == TURN_LAST) begin
                  state_d  = exp_rsp_q ? RX_WAIT : IDLE;
                  to_cnt_d = '0;
               end else begin
                  per_d = per_q + PW'(1);
               end
            end
         end
         RX_WAIT: begin
            // Counts on through RX_START so a rejected glitch does not push
            // the timeout out; a start edge beats an expiring timeout.
            to_cnt_d = to_cnt_q + TW'(1);
            if (start_edge) begin
               state_d = RX_START;
            end else if (to_cnt_q >= TO_LIMIT) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         RX_START: begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (bit_cnt_q == BIT_MID) begin
               state_d = line_s ? RX_WAIT : RX_DATA;
            end
         end
         RX_DATA: begin
            // Timer restarted at the mid-start sample, so bit_end is mid-bit.
            if (bit_end) begin
               rx_sh_d = {line_s, rx_sh_q[DATA_W-1:1]};
               if (per_q == DATA_LAST) begin
`ifdef IOPAD_HDX_PARITY_EN
                  state_d = RX_PARITY;
`else
                  state_d = RX_STOP;
`endif
               end else begin
                  per_d = per_q + PW'(1);
               end
            end
         end
`ifdef IOPAD_HDX_PARITY_EN
         RX_PARITY: begin
            if (bit_end) begin
               par_err_d = line_s ^ (^rx_sh_q);
               state_d   = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (bit_end) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rx_sh_q;
`ifdef IOPAD_HDX_PARITY_EN
               rx_err_d   = ~line_s | par_err_q;
`else
               rx_err_d   = ~line_s;
`endif
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) begin
         bit_cnt_d = '0;
         per_d     = '0;
      end

      // Pad controls come from the next state so they are clean flop outputs
      // that change together with the state register.
      pad_oen_d = (state_d == TX_START) || (state_d == TX_DATA) ||
                  (state_d == TX_PARITY) || (state_d == TX_STOP);
      case (state_d)
         TX_START:  pad_inp_d = 1'b0;
         TX_DATA:   pad_inp_d = tx_byte_d[per_d[IW-1:0]];
         TX_PARITY: pad_inp_d = ^tx_byte_d;
         default:   pad_inp_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         per_q       <= '0;
         to_cnt_q    <= '0;
         tx_byte_q   <= '0;
         exp_rsp_q   <= 1'b0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_err_q    <= 1'b0;
         rx_valid_q  <= 1'b0;
         pad_oen_q   <= 1'b0;
         pad_inp_q   <= 1'b1;
         line_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         per_q       <= per_d;
         to_cnt_q    <= to_cnt_d;
         tx_byte_q   <= tx_byte_d;
         exp_rsp_q   <= exp_rsp_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_err_q    <= rx_err_d;
         rx_valid_q  <= rx_valid_d;
         pad_oen_q   <= pad_oen_d;
         pad_inp_q   <= pad_inp_d;
         line_prev_q <= line_s;
      end
   end

`ifdef IOPAD_HDX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end
`endif

   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign rx_err   = rx_err_q;
   assign pad_oen  = pad_oen_q;
   assign pad_inp  = pad_inp_q;

endmodule

// File: tb/tb_iopad_hdx_link.sv
// Testbench for iopad_hdx_link: table of transactions plus random ones, with
// the expected pad waveform and response built from the UART frame rules.
`timescale 1ns/1ps
module tb_iopad_hdx_link;

   localparam int CPB  = 16;
   localparam int TURN = 2;
   localparam int TOB  = 64;
`ifdef IOPAD_HDX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   localparam int M_SILENT  = 0;
   localparam int M_GOOD    = 1;
   localparam int M_BADSTOP = 2;
   localparam int M_GLITCH  = 3;
   localparam int M_BADPAR  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       expect_rsp = 1'b0;
   logic       pad_outp = 1'b1;
   logic       tx_ready, rx_valid, rx_err, timeout, busy, pad_inp, pad_oen;
   logic [7:0] rx_data;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  hold_data = 8'h00;
   logic        hold_err = 1'b0;
   logic [10:0] last_cap;

   typedef struct {
      logic [7:0] tx;
      logic       rsp;
      int         mode;
      logic [7:0] rb;
      int         dly;
      logic       e_valid;
      logic [7:0] e_data;
      logic       e_err;
      logic       e_to;
   } vec_t;

   iopad_hdx_link #(
      .CLKS_PER_BIT (CPB),
      .TURN_BITS    (TURN),
      .TIMEOUT_BITS (TOB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .expect_rsp (expect_rsp),
      .tx_ready   (tx_ready),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_err     (rx_err),
      .timeout    (timeout),
      .busy       (busy),
      .pad_inp    (pad_inp),
      .pad_oen    (pad_oen),
      .pad_outp   (pad_outp)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wire frame, index 0 first on the line: start, data LSB first, [parity], stop.
   function automatic logic [10:0] frame_of(input logic [7:0] b, input logic stop, input logic pflip);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
      if (NB == 11) begin
         f[9]  = (^b) ^ pflip;
         f[10] = stop;
      end else begin
         f[9]  = stop;
      end
      return f;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      logic [10:0] txf, rf, cap;
      int n, c, c0, rdy_c, v_c, to_c, n_v, n_to;
      logic [7:0] got_d;
      logic got_e, line, oen_bad;
      txf = frame_of(v.tx, 1'b1, 1'b0);
      rf  = frame_of(v.rb, v.mode != M_BADSTOP, v.mode == M_BADPAR);
      cap = '1;
      c0  = v.dly * CPB;
      got_d = 8'h00;
      got_e = 1'b0;

      n = 0;
      while (tx_ready !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (tx_ready !== 1'b1) begin
         chk({tag, "_idle_wait"}, tx_ready, 1);
         return;
      end
      tx_valid = 1'b1; tx_data = v.tx; expect_rsp = v.rsp;
      @(negedge clk);
      chk({tag, "_ready_drop"}, tx_ready, 0);
      chk({tag, "_busy"}, busy, 1);

      // TX phase: extra tx_valid pulses here must be ignored.
      n = 0;
      while (pad_oen === 1'b1 && n < (NB + 2) * CPB) begin
         if (n % CPB == CPB / 2 && n / CPB < 11) cap[n / CPB] = pad_inp;
         tx_valid = 1'b1; tx_data = 8'($urandom); expect_rsp = 1'($urandom);
         @(negedge clk);
         n++;
      end
      tx_valid = 1'b0;
      chk({tag, "_oen_cycles"}, n, NB * CPB);
      chk({tag, "_tx_frame"}, cap, txf);
      last_cap = cap;

      // Released phase: c = 0 is the first cycle with the pad released.
      n_v = 0; n_to = 0; rdy_c = -1; v_c = -1; to_c = -1; oen_bad = 1'b0;
      for (c = 0; c < (TURN + TOB + NB + 4) * CPB; c++) begin
         if (rx_valid === 1'b1) begin
            n_v++; v_c = c; got_d = rx_data; got_e = rx_err;
         end
         if (timeout === 1'b1) begin
            n_to++; to_c = c;
         end
         if (pad_oen !== 1'b0) oen_bad = 1'b1;
         if (tx_ready === 1'b1) begin
            rdy_c = c;
            break;
         end
         line = 1'b1;
         if (v.mode == M_GLITCH) line = !(c >= c0 && c < c0 + 3);
         else if (v.mode != M_SILENT && c >= c0 && c < c0 + NB * CPB) line = rf[(c - c0) / CPB];
         pad_outp = line;
         @(negedge clk);
      end
      pad_outp = 1'b1;

      chk({tag, "_released"}, oen_bad, 0);
      chk({tag, "_returns_idle"}, rdy_c >= 0, 1);
      if (!v.rsp) chk({tag, "_turn_len"}, rdy_c, TURN * CPB);
      chk({tag, "_rx_valid_count"}, n_v, v.e_valid);
      chk({tag, "_timeout_count"}, n_to, v.e_to);
      if (v.e_valid && n_v == 1) begin
         chk({tag, "_rx_data"}, got_d, v.e_data);
         chk({tag, "_rx_err"}, got_e, v.e_err);
         chk({tag, "_rx_time"}, (v_c >= c0 + (NB - 1) * CPB) && (v_c <= c0 + NB * CPB + 4), 1);
      end
      if (v.e_to && n_to == 1) begin
         chk({tag, "_timeout_time"}, to_c, (TURN + TOB) * CPB);
         chk({tag, "_ready_after_to"}, rdy_c, to_c + 1);
      end
      if (v.e_valid) begin
         hold_data = v.e_data;
         hold_err  = v.e_err;
      end
      chk({tag, "_rx_data_hold"}, rx_data, hold_data);
      chk({tag, "_rx_err_hold"}, rx_err, hold_err);
   endtask

   initial begin
      vec_t tbl[5];
      vec_t v;
      logic seen;

      tbl[0] = '{8'hA5, 1'b0, M_SILENT,  8'h00, 5, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{8'h3C, 1'b1, M_GOOD,    8'h5A, 5, 1'b1, 8'h5A, 1'b0, 1'b0};
      tbl[2] = '{8'h81, 1'b1, M_BADSTOP, 8'hFF, 4, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[3] = '{8'h42, 1'b1, M_SILENT,  8'h00, 5, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[4] = '{8'h18, 1'b1, M_GLITCH,  8'h00, 5, 1'b0, 8'h00, 1'b0, 1'b1};

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pad_oen", pad_oen, 0);
      chk("rst_pad_inp", pad_inp, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_err", rx_err, 0);
      chk("rst_timeout", timeout, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_txn(tbl[i], $sformatf("tbl%0d", i));
      end

`ifdef IOPAD_HDX_PARITY_EN
      v = '{8'h07, 1'b1, M_GOOD, 8'h96, 4, 1'b1, 8'h96, 1'b0, 1'b0};
      run_txn(v, "par_good");
      chk("par_tx_bit", last_cap[9], 1);
      v = '{8'h00, 1'b1, M_BADPAR, 8'h81, 4, 1'b1, 8'h81, 1'b1, 1'b0};
      run_txn(v, "par_bad");
`endif

      // Random transactions
      for (int i = 0; i < 10; i++) begin
         v.tx   = 8'($urandom);
         v.rsp  = 1'($urandom);
         v.rb   = 8'($urandom);
         v.dly  = $urandom_range(3, 9);
         v.mode = v.rsp ? int'($urandom_range(1, (NB == 11) ? 4 : 2)) : M_SILENT;
         if (v.mode == M_GLITCH) v.mode = M_GOOD;
         v.e_valid = v.rsp;
         v.e_data  = v.rsp ? v.rb : 8'h00;
         v.e_err   = (v.mode == M_BADSTOP) || (v.mode == M_BADPAR);
         v.e_to    = 1'b0;
         run_txn(v, $sformatf("rnd%0d", i));
      end

      // Reset in the middle of TX_DATA
      seen = 1'b0;
      for (int n = 0; n < 4000 && tx_ready !== 1'b1; n++) @(negedge clk);
      tx_valid = 1'b1; tx_data = 8'hC3; expect_rsp = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (40) @(negedge clk);
      chk("mid_pre_oen", pad_oen, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_pad_oen", pad_oen, 0);
      chk("mid_rst_pad_inp", pad_inp, 1);
      chk("mid_rst_tx_ready", tx_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rx_data", rx_data, 0);
      chk("mid_rst_rx_err", rx_err, 0);
      chk("mid_rst_rx_valid", rx_valid, 0);
      chk("mid_rst_timeout", timeout, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if (rx_valid !== 1'b0 || timeout !== 1'b0 || pad_oen !== 1'b0 || tx_ready !== 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      chk("post_rst_quiet", seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
